// File: rtl/character_motion_ctrl.sv
// Per-character motion controller. Left/right/jump button levels become
// registered sprite coordinates. Two free-running prescalers set the walk
// and jump rates. The sprite is clamped to the playfield, and a restart
// returns it to the spawn point.
//
// state  | meaning
// -------+---------------------------------------------------------------
// GROUND | standing on the ground line, waiting for a jump press
// RISE   | moving up one pixel per jump tick until height or ceiling
// FALL   | moving down one pixel per jump tick until the ground line
module character_motion_ctrl #(
    parameter int POS_W       = 12,
    parameter int MOVE_TICK   = 250_000,
    parameter int JUMP_TICK   = 1_400_000,
    parameter int JUMP_HEIGHT = 58,
    parameter int CHAR_W      = 48,
    parameter int INIT_XPOS   = 128,
    parameter int INIT_YPOS   = 672,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 1024,
    parameter int Y_MIN       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             restart,
    input  logic             left,
    input  logic             right,
    input  logic             jump,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             airborne,
    output logic             facing_left
);

    localparam int MCW = (MOVE_TICK > 1) ? $clog2(MOVE_TICK) : 1;
    localparam int JCW = (JUMP_TICK > 1) ? $clog2(JUMP_TICK) : 1;
    localparam int HW  = $clog2(JUMP_HEIGHT + 1);

    localparam logic [MCW-1:0]   MOVE_LAST  = MCW'(MOVE_TICK - 1);
    localparam logic [JCW-1:0]   JUMP_LAST  = JCW'(JUMP_TICK - 1);
    localparam logic [HW-1:0]    HEIGHT_TOP = HW'(JUMP_HEIGHT);
    localparam logic [POS_W-1:0] X_LO       = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] X_HI       = POS_W'(X_MAX - CHAR_W);
    localparam logic [POS_W-1:0] Y_TOP      = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] Y_GND      = POS_W'(INIT_YPOS);
    localparam logic [POS_W-1:0] X_SPAWN    = POS_W'(INIT_XPOS);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [MCW-1:0]   move_cnt;
    logic [JCW-1:0]   jump_cnt;
    logic [HW-1:0]    height;
    logic [HW-1:0]    height_nx;
    logic [HW-1:0]    height_inc;
    logic [POS_W-1:0] xpos_nx;
    logic [POS_W-1:0] ypos_nx;
    logic             facing_nx;
    logic             jump_prev;
    logic             jump_edge;
    logic             move_tick;
    logic             jump_tick;

    assign move_tick  = (move_cnt == MOVE_LAST);
    assign jump_tick  = (jump_cnt == JUMP_LAST);
    assign jump_edge  = jump & ~jump_prev;
    assign height_inc = height + HW'(1);

    // Rate prescalers: free-running while enabled, parked at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_cnt <= '0;
            jump_cnt <= '0;
        end else if (restart || !enable) begin
            move_cnt <= '0;
            jump_cnt <= '0;
        end else begin
            move_cnt <= move_tick ? '0 : move_cnt + MCW'(1);
            jump_cnt <= jump_tick ? '0 : jump_cnt + JCW'(1);
        end
    end

    // Next-state logic for the vertical FSM, horizontal walk and facing.
    always_comb begin
        state_nx  = state;
        xpos_nx   = xpos;
        ypos_nx   = ypos;
        height_nx = height;
        facing_nx = facing_left;

        if (left && !right) begin
            facing_nx = 1'b1;
        end else if (right && !left) begin
            facing_nx = 1'b0;
        end

        // Limit checks use the current position, so the walk cannot wrap.
        if (move_tick) begin
            if (left && !right && (xpos > X_LO)) begin
                xpos_nx = xpos - POS_W'(1);
            end else if (right && !left && (xpos < X_HI)) begin
                xpos_nx = xpos + POS_W'(1);
            end
        end

        case (state)
            GROUND: begin
                if (jump_edge) begin
                    state_nx  = RISE;
                    height_nx = '0;
                end
            end
            RISE: begin
                if (jump_tick) begin
                    if (ypos == Y_TOP) begin
                        state_nx = FALL;
                    end else begin
                        ypos_nx   = ypos - POS_W'(1);
                        height_nx = height_inc;
                        if (height_inc == HEIGHT_TOP) begin
                            state_nx = FALL;
                        end
                    end
                end
            end
            FALL: begin
                // At or below the ground line: land at once, no tick needed.
                if (ypos >= Y_GND) begin
                    ypos_nx  = Y_GND;
                    state_nx = GROUND;
                end else if (jump_tick) begin
                    ypos_nx = ypos + POS_W'(1);
                    if ((ypos + POS_W'(1)) == Y_GND) begin
                        state_nx = GROUND;
                    end
                end
            end
            default: begin
                state_nx = GROUND;
            end
        endcase
    end

    // State register; airborne is registered with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= GROUND;
            airborne <= 1'b0;
        end else if (restart) begin
            state    <= GROUND;
            airborne <= 1'b0;
        end else if (enable) begin
            state    <= state_nx;
            airborne <= (state_nx != GROUND);
        end
    end

    // Position and height registers. Facing and the jump history keep
    // tracking the buttons while frozen, so a press made during the freeze
    // cannot trigger a jump once motion resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xpos        <= X_SPAWN;
            ypos        <= Y_GND;
            height      <= '0;
            facing_left <= 1'b0;
            jump_prev   <= 1'b0;
        end else if (restart) begin
            xpos        <= X_SPAWN;
            ypos        <= Y_GND;
            height      <= '0;
            facing_left <= 1'b0;
            jump_prev   <= 1'b0;
        end else begin
            facing_left <= facing_nx;
            jump_prev   <= jump;
            if (enable) begin
                xpos   <= xpos_nx;
                ypos   <= ypos_nx;
                height <= height_nx;
            end
        end
    end

endmodule

// File: tb/tb_character_motion_ctrl.sv
// Directed bench for character_motion_ctrl with small tick rates. A second
// instance uses a low spawn height so that the ceiling stop can be reached.
module tb_character_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        jump = 1'b0;
    logic [11:0] xpos, ypos, xpos2, ypos2;
    logic        airborne, facing_left, airborne2, facing_left2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        en;
        logic        rs;
        logic        l;
        logic        r;
        logic        j;
        int          n;
        logic [11:0] ex;
        logic [11:0] ey;
        logic        ea;
        logic        ef;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    character_motion_ctrl #(
        .POS_W(12), .MOVE_TICK(4), .JUMP_TICK(2), .JUMP_HEIGHT(5),
        .CHAR_W(48), .INIT_XPOS(128), .INIT_YPOS(672),
        .X_MIN(0), .X_MAX(180), .Y_MIN(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
        .left(left), .right(right), .jump(jump),
        .xpos(xpos), .ypos(ypos), .airborne(airborne),
        .facing_left(facing_left)
    );

    character_motion_ctrl #(
        .POS_W(12), .MOVE_TICK(4), .JUMP_TICK(2), .JUMP_HEIGHT(5),
        .CHAR_W(48), .INIT_XPOS(128), .INIT_YPOS(3),
        .X_MIN(0), .X_MAX(180), .Y_MIN(1)
    ) dut_ceil (
        .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
        .left(left), .right(right), .jump(jump),
        .xpos(xpos2), .ypos(ypos2), .airborne(airborne2),
        .facing_left(facing_left2)
    );

    task automatic chk(input string nm, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d expected=%0d", nm, idx, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rs, input logic l,
                         input logic r, input logic j);
        enable  = en;
        restart = rs;
        left    = l;
        right   = r;
        jump    = j;
    endtask

    // Advance n clocks, then sit 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic rs, input logic l, input logic r,
                       input logic j, input int n, input int ex, input int ey,
                       input logic ea, input logic ef);
        vec_t v;
        v.en = en; v.rs = rs; v.l = l; v.r = r; v.j = j; v.n = n;
        v.ex = 12'(ex); v.ey = 12'(ey); v.ea = ea; v.ef = ef;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //  en rs l  r  j   n    x    y    air face
        add(1, 0, 0, 1, 0,   3, 128, 672, 0, 0);  // walk right, before first tick
        add(1, 0, 0, 1, 0,   1, 129, 672, 0, 0);  // first step on clock 4
        add(1, 0, 0, 1, 0,  36, 132, 672, 0, 0);  // 40 clocks: saturated
        add(1, 0, 0, 1, 0,  60, 132, 672, 0, 0);  // stays at right limit
        add(1, 0, 1, 0, 0,   1, 132, 672, 0, 1);  // facing flips at once
        add(1, 0, 1, 0, 0, 600,   0, 672, 0, 1);  // walks to left limit and stays
        add(1, 1, 0, 0, 0,   1, 128, 672, 0, 0);  // restart
        add(1, 0, 0, 0, 1,   1, 128, 672, 1, 0);  // jump pulse -> airborne
        add(1, 0, 0, 0, 0,   1, 128, 671, 1, 0);
        add(1, 0, 0, 0, 0,   8, 128, 667, 1, 0);  // peak
        add(1, 0, 0, 0, 0,   9, 128, 671, 1, 0);
        add(1, 0, 0, 0, 0,   1, 128, 672, 0, 0);  // landed after 10 ticks
        add(1, 0, 0, 0, 0,   4, 128, 672, 0, 0);
        add(1, 0, 0, 0, 1,   1, 128, 672, 1, 0);  // held jump
        add(1, 0, 0, 0, 1,  19, 128, 672, 0, 0);  // lands while held
        add(1, 0, 0, 0, 1,  10, 128, 672, 0, 0);  // no retrigger
        add(1, 0, 0, 0, 0,   2, 128, 672, 0, 0);
        add(1, 0, 0, 0, 1,   1, 128, 672, 1, 0);
        add(1, 0, 0, 0, 0,   1, 128, 671, 1, 0);
        add(1, 0, 0, 0, 1,   3, 128, 670, 1, 0);  // mid-air edge ignored
        add(1, 0, 0, 0, 0,   5, 128, 667, 1, 0);  // peak unchanged
        add(1, 0, 0, 0, 0,   2, 128, 668, 1, 0);
        add(1, 0, 0, 0, 0,   8, 128, 672, 0, 0);
        add(1, 0, 0, 1, 0,   8, 130, 672, 0, 0);
        add(1, 0, 0, 0, 1,   1, 130, 672, 1, 0);
        add(1, 0, 0, 0, 0,   5, 130, 669, 1, 0);
        add(1, 1, 1, 0, 0,   1, 128, 672, 0, 0);  // restart beats left
        add(1, 0, 0, 0, 1,   1, 128, 672, 1, 0);
        add(1, 0, 0, 0, 0,  12, 128, 668, 1, 0);  // falling
        add(0, 0, 1, 0, 0,  20, 128, 668, 1, 1);  // frozen, facing updates
        add(1, 0, 0, 0, 0,   1, 128, 668, 1, 1);
        add(1, 0, 0, 0, 0,   1, 128, 669, 1, 1);  // JUMP_TICK clocks after resume
        add(1, 1, 0, 0, 0,   1, 128, 672, 0, 0);

        @(posedge clk);
        #1;
        chk("reset_xpos", 0, xpos, 128);
        chk("reset_ypos", 0, ypos, 672);
        chk("reset_air", 0, airborne, 0);
        chk("reset_face", 0, facing_left, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].rs, vecs[i].l, vecs[i].r, vecs[i].j);
            step(vecs[i].n);
            chk("xpos", i, xpos, vecs[i].ex);
            chk("ypos", i, ypos, vecs[i].ey);
            chk("airborne", i, airborne, vecs[i].ea);
            chk("facing_left", i, facing_left, vecs[i].ef);
        end

        // Ceiling stop: spawn y=3, ceiling y=1, height limit never reached.
        drive(1, 0, 0, 0, 1); step(1);
        chk("ceil_air", 0, airborne2, 1);
        drive(1, 0, 0, 0, 0); step(4);
        chk("ceil_ypos", 1, ypos2, 1);
        step(2);
        chk("ceil_ypos", 2, ypos2, 1);
        chk("ceil_air", 2, airborne2, 1);
        step(1);
        chk("ceil_ypos", 3, ypos2, 2);
        step(2);
        chk("ceil_ypos", 4, ypos2, 3);
        chk("ceil_air", 4, airborne2, 0);

        // Async reset mid-jump: takes effect before the next clock edge.
        drive(1, 0, 1, 0, 0); step(1);
        chk("pre_rst_ypos", 0, ypos, 667);
        chk("pre_rst_face", 0, facing_left, 1);
        chk("pre_rst_air", 0, airborne, 1);
        rst_n = 1'b0;
        #2;
        chk("async_xpos", 0, xpos, 128);
        chk("async_ypos", 0, ypos, 672);
        chk("async_air", 0, airborne, 0);
        chk("async_face", 0, facing_left, 0);
        #1;
        rst_n = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/character_motion_ctrl.md
Name: character_motion_ctrl

Overview:
- Parametrised per-character motion controller: converts left/right/jump button levels into registered sprite coordinates.
- Horizontal walking, a rise/fall jump state machine, playfield clamping, and restart to the spawn point.
- Motion rates come from prescaled tick counters.
- One instance per character (donkey, kong, ...) between the input decoder and the sprite draw blocks.

Parameters:
POS_W, 12, width of xpos/ypos
MOVE_TICK, 250_000, clocks per 1-pixel horizontal step (>=2)
JUMP_TICK, 1_400_000, clocks per 1-pixel vertical step (>=2)
JUMP_HEIGHT, 58, pixels risen before falling (>=1)
CHAR_W, 48, sprite width in pixels
INIT_XPOS, 128, spawn x
INIT_YPOS, 672, spawn y; also the ground line
X_MIN, 0, leftmost legal xpos
X_MAX, 1024, right playfield edge; xpos limited to X_MAX-CHAR_W
Y_MIN, 0, ceiling; rise stops here

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  game running; low freezes all motion
restart  in  1  synchronous reload to spawn, one-cycle pulse or level
left  in  1  move-left button level
right  in  1  move-right button level
jump  in  1  jump button level
xpos  out  POS_W  sprite left x
ypos  out  POS_W  sprite top y
airborne  out  1  high in RISE or FALL
facing_left  out  1  sprite mirror select

Behaviour:
- Reset (rst_n=0, async):
  - xpos=INIT_XPOS, ypos=INIT_YPOS; state GROUND.
  - airborne=0, facing_left=0.
  - Both prescalers 0; height counter 0; jump_prev=0.
- Priority each cycle: restart > !enable > normal operation.
- restart=1: same values as reset, applied on the next edge; overrides any in-progress jump or tick.
- enable=0:
  - Prescalers held at 0; position, state and height held.
  - facing_left and jump_prev still update.
- Prescalers:
  - move_cnt counts 0..MOVE_TICK-1 and wraps; move_tick is the combinational pulse when move_cnt==MOVE_TICK-1.
  - jump_cnt/jump_tick identical with JUMP_TICK.
  - Both run free while enable=1, independent of buttons.
- Horizontal, on move_tick:
  - left&!right and xpos>X_MIN: xpos-1.
  - right&!left and xpos<X_MAX-CHAR_W: xpos+1.
  - Both or neither pressed: hold.
  - Applies in every state, so airborne steering is allowed.
  - No wrap-around: clamps at the limits.
- facing_left, every enabled cycle: set on left&!right, cleared on right&!left, otherwise held.
- Jump edge: jump_prev<=jump each cycle; jump_edge=jump&!jump_prev. A held button never retriggers, including on landing.
- Vertical FSM:
  - GROUND: on jump_edge go to RISE and clear height. Transition on the edge; first movement on the next jump_tick. No vertical motion in GROUND.
  - RISE, on jump_tick:
    - If ypos==Y_MIN: go to FALL with no move (ceiling).
    - Else ypos-1, height+1; if height+1==JUMP_HEIGHT, go to FALL in the same cycle.
  - FALL, on jump_tick: ypos+1; if ypos+1==INIT_YPOS, go to GROUND.
  - A FALL entered with ypos>=INIT_YPOS snaps ypos to INIT_YPOS and goes to GROUND.
  - jump_edge during RISE/FALL is ignored (no double jump).
- airborne is registered: equals (state!=GROUND), updated with state.
- Latency: outputs change on the clock edge that ends the tick cycle; all outputs are registered, no combinational input-to-output path.
- A jump_tick coinciding with a move_tick updates both axes in the same cycle.
- Arithmetic: unsigned POS_W. Limit compares use pre-update values, so underflow/overflow never occurs.

Test Plan (MOVE_TICK=4, JUMP_TICK=2, JUMP_HEIGHT=5, X_MIN=0, X_MAX=180, CHAR_W=48, INIT 128/672):
- Reset, then right held 40 clocks -> xpos 128->132 (one step per 4 clocks, xpos=129 first on clock 4), facing_left=0, ypos=672, airborne=0.
- Right held 100 clocks from 128 -> xpos saturates at 132 (=X_MAX-CHAR_W) and stays; left held 600 clocks -> xpos reaches 0 and stays.
- Single jump pulse -> airborne=1 next cycle; ypos 672->667 (one step per 2 clocks), then back to 672; airborne=0 on landing; total 10 ticks.
- jump held through the whole jump and landing -> exactly one jump; second jump_edge mid-air -> ignored, peak still 667.
- restart asserted mid-rise at ypos=669, xpos=130 -> next cycle xpos=128, ypos=672, airborne=0, facing_left=0.
- enable=0 for 20 clocks mid-fall with left held -> position frozen; facing_left=1 updates; resuming, first step lands JUMP_TICK clocks after enable rises; rst_n pulsed mid-jump -> immediate async return to 128/672.
